// File: rtl/l2_config_and_types.sv
// Package l2_config_and_types
// Purpose : shared configuration constants and data types for the L2 arbiter
//           read-return path.
// Contents: port count / field widths, attribute record written at issue
//           time, memory return beat, per-port return record, and the state
//           type of the return router.
package l2_config_and_types;

  localparam int L2_NUM_PORTS               = 2;
  localparam int L2_ID_W                    = (L2_NUM_PORTS > 1) ? $clog2(L2_NUM_PORTS) : 1;
  localparam int L2_SUB_ID_W                = 4;
  localparam int L2_DATA_W                  = 32;
  localparam int L2_BURST_W                 = 3;   // burst_size encodes beats-1
  localparam int L2_READ_RETURN_FIFO_DEPTHS = 1;

  typedef logic [L2_ID_W-1:0]     l2_port_id_t;
  typedef logic [L2_SUB_ID_W-1:0] l2_sub_id_t;
  typedef logic [L2_DATA_W-1:0]   l2_data_t;

  typedef struct packed {
    l2_port_id_t           id;
    logic [L2_BURST_W-1:0] burst_size;
    logic                  abort;
  } l2_data_attributes_t;

  typedef struct packed {
    l2_port_id_t id;
    l2_sub_id_t  sub_id;
    l2_data_t    data;
  } l2_mem_return_data_t;

  typedef struct packed {
    l2_sub_id_t sub_id;
    l2_data_t   data;
  } l2_return_data_t;

  typedef enum logic {L2_RET_IDLE, L2_RET_BURST} l2_return_state_t;

endpackage

// File: rtl/l2_return_fifo.sv
// Module l2_return_fifo
// Purpose : small synchronous FIFO holding read-return records for one port.
//           DEPTH=1 collapses to a single holding register; larger depths use
//           a circular buffer with wrapping pointers and an occupancy counter.
// Ports   : clk, rst_n       clock, async active-low reset
//           i_push/i_push_data  write request (ignored when full)
//           i_pop           read request (ignored when empty)
//           o_full/o_empty  registered status
//           o_head          oldest entry (valid when !o_empty)
module l2_return_fifo #(
  parameter int  DEPTH  = 1,
  parameter type DATA_T = logic [7:0]
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_push,
  input  DATA_T i_push_data,
  input  logic  i_pop,
  output logic  o_full,
  output logic  o_empty,
  output DATA_T o_head
);

  generate
    if (DEPTH == 1) begin : g_single
      logic  r_valid;
      DATA_T r_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (i_push && !r_valid) begin
          r_valid <= 1'b1;
          r_data  <= i_push_data;
        end else if (i_pop && r_valid) begin
          r_valid <= 1'b0;
        end
      end

      assign o_full  = r_valid;
      assign o_empty = !r_valid;
      assign o_head  = r_data;
    end else begin : g_multi
      localparam int PW = $clog2(DEPTH);
      localparam int CW = $clog2(DEPTH + 1);

      logic [PW-1:0] r_wr_ptr;
      logic [PW-1:0] r_rd_ptr;
      logic [CW-1:0] r_count;
      DATA_T         r_mem [DEPTH];
      logic          w_push;
      logic          w_pop;

      assign o_full  = (r_count == CW'(DEPTH));
      assign o_empty = (r_count == '0);
      assign w_push  = i_push && !o_full;
      assign w_pop   = i_pop && !o_empty;
      assign o_head  = r_mem[r_rd_ptr];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push)
            r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
          if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      // Storage carries no reset; only the pointers define validity.
      always_ff @(posedge clk) begin
        if (w_push)
          r_mem[r_wr_ptr] <= i_push_data;
      end
    end
  endgenerate

endmodule

// File: rtl/l2_return_router.sv
// Module l2_return_router
// Purpose : routes memory read-return beats to per-port return FIFOs using
//           the in-order attribute queue written at issue time. Beats of
//           aborted requests are drained and dropped.
// Ports   : clk, rst_n                 clock, async active-low reset
//           attr_valid/attr/attr_pop   attribute queue head and pop strobe
//           mem_rd_data_valid/_ready   memory beat handshake, mem_rd_data beat
//           rd_data_valid/rd_data      per-port FIFO status and head
//           rd_data_ack                per-port pop
//           id_mismatch_err            sticky beat-id vs active-id error
module l2_return_router
  import l2_config_and_types::*;
#(
  parameter int RETURN_FIFO_DEPTH = L2_READ_RETURN_FIFO_DEPTHS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      attr_valid,
  input  l2_data_attributes_t       attr,
  output logic                      attr_pop,
  input  logic                      mem_rd_data_valid,
  input  l2_mem_return_data_t       mem_rd_data,
  output logic                      mem_rd_data_ready,
  output logic [L2_NUM_PORTS-1:0]   rd_data_valid,
  output l2_return_data_t           rd_data [L2_NUM_PORTS],
  input  logic [L2_NUM_PORTS-1:0]   rd_data_ack,
  output logic                      id_mismatch_err
);

  l2_return_state_t      r_state;
  l2_return_state_t      w_next_state;
  l2_port_id_t           r_id;
  logic                  r_abort;
  logic [L2_BURST_W-1:0] r_count;
  logic                  r_err;

  logic                    w_load;
  logic                    w_accept;
  logic [L2_NUM_PORTS-1:0] w_push;
  logic [L2_NUM_PORTS-1:0] w_full;
  logic [L2_NUM_PORTS-1:0] w_empty;
  l2_return_data_t         w_ret;

  assign w_ret = '{sub_id: mem_rd_data.sub_id, data: mem_rd_data.data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= L2_RET_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state      = r_state;
    w_load            = 1'b0;
    w_accept          = 1'b0;
    mem_rd_data_ready = 1'b0;
    attr_pop          = 1'b0;
    case (r_state)
      L2_RET_IDLE: begin
        if (attr_valid) begin
          w_load       = 1'b1;
          w_next_state = L2_RET_BURST;
        end
      end
      L2_RET_BURST: begin
        // Aborted bursts are sunk regardless of FIFO space. Full is the
        // registered status, so a same-cycle pop does not open the gate.
        mem_rd_data_ready = r_abort || !w_full[r_id];
        w_accept          = mem_rd_data_ready && mem_rd_data_valid;
        if (w_accept && (r_count == '0)) begin
          attr_pop     = 1'b1;
          w_next_state = L2_RET_IDLE;
        end
      end
      default: w_next_state = L2_RET_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= '0;
      r_abort <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load) begin
        r_id    <= attr.id;
        r_abort <= attr.abort;
        r_count <= attr.burst_size;
      end else if (w_accept && (r_count != '0)) begin
        r_count <= r_count - 1'b1;
      end
      // Routing always follows the active attribute; a disagreeing beat id
      // is only flagged.
      if (w_accept && (mem_rd_data.id != r_id))
        r_err <= 1'b1;
    end
  end

  assign id_mismatch_err = r_err;

  genvar gi;
  generate
    for (gi = 0; gi < L2_NUM_PORTS; gi++) begin : g_port
      assign w_push[gi]        = w_accept && !r_abort && (r_id == L2_ID_W'(gi));
      assign rd_data_valid[gi] = !w_empty[gi];

      l2_return_fifo #(
        .DEPTH  (RETURN_FIFO_DEPTH),
        .DATA_T (l2_return_data_t)
      ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push[gi]),
        .i_push_data (w_ret),
        .i_pop       (rd_data_ack[gi]),
        .o_full      (w_full[gi]),
        .o_empty     (w_empty[gi]),
        .o_head      (rd_data[gi])
      );
    end
  endgenerate

endmodule
